if_stage_ctrl: RTL and testbench

//  Fetch-side responder to the load-use hazard/stall signal and to branch flush.

---
 rtl/if_pkg.sv | 14 +
 rtl/if_skid_buf.sv | 27 ++
 rtl/if_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_if_stage_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HELD    = 2'd2,
    DISCARD = 2'd3
  } if_state_e;

  localparam int NOP_INSTR = 0;
  localparam int PC_INC    = 4;

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - single-entry holding register for an instruction returned during a stall
module if_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] data,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage_ctrl.sv
// rtl/if_stage_ctrl.sv - fetch controller: PC, IF/ID register, imem handshake, stall/flush response
module if_stage_ctrl
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0]  if_id_pc_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic               if_id_valid_o,
  output logic               bubble_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  if_state_e          state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next_seq;
  logic [ADDR_W-1:0]  target;
  logic               flush_ok;
  logic               skid_load;
  logic               skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_data;

  assign target      = branch_target_i & ~ADDR_W'(3);
  assign pc_next_seq = pc + ADDR_W'(PC_INC);
  assign flush_ok    = flush_i & ~stall_i;
  assign skid_load   = (state == FETCH) & imem_ack_i & stall_i;
  assign skid_clear  = (state == HELD) & ~stall_i;
  assign bubble_o    = stall_i & if_id_valid_o;

  if_skid_buf #(.W(INSTR_W)) u_skid (
    .clk       (clk_i),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (imem_data_i),
    .data      (skid_data),
    .valid     (skid_valid)
  );

  // imem_addr_o is its own register so a DISCARD transaction keeps its stale address
  // while pc already points at the branch target.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      imem_addr_o   <= RESET_PC;
      imem_req_o    <= 1'b0;
      if_id_pc_o    <= '0;
      if_id_instr_o <= NOP;
      if_id_valid_o <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= FETCH;
          imem_req_o  <= 1'b1;
          imem_addr_o <= pc;
        end
        FETCH: begin
          if (stall_i) begin
            if (imem_ack_i) begin
              state      <= HELD;
              imem_req_o <= 1'b0;
            end
          end else if (flush_i) begin
            pc            <= target;
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP;
            if (imem_ack_i) imem_addr_o <= target;
            else            state       <= DISCARD;
          end else if (imem_ack_i) begin
            if_id_pc_o    <= pc;
            if_id_instr_o <= imem_data_i;
            if_id_valid_o <= 1'b1;
            pc            <= pc_next_seq;
            imem_addr_o   <= pc_next_seq;
          end else begin
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP;
          end
        end
        HELD: begin
          if (!stall_i) begin
            state      <= FETCH;
            imem_req_o <= 1'b1;
            if (flush_i) begin
              pc            <= target;
              imem_addr_o   <= target;
              if_id_valid_o <= 1'b0;
              if_id_instr_o <= NOP;
            end else begin
              if_id_pc_o    <= pc;
              if_id_instr_o <= skid_data;
              if_id_valid_o <= skid_valid;
              pc            <= pc_next_seq;
              imem_addr_o   <= pc_next_seq;
            end
          end
        end
        DISCARD: begin
          // The closing ack is always consumed; only a non-stalled flush retargets pc.
          if (flush_ok) pc <= target;
          if (imem_ack_i) begin
            state       <= FETCH;
            imem_addr_o <= flush_ok ? target : pc;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (stall_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb/tb_if_stage_ctrl.sv - self-checking bench for if_stage_ctrl against a behavioural fetch model
module tb_if_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        bubble_o;
  logic [15:0] stall_cnt_o;

  int tests = 0;
  int fails = 0;
  bit do_cmp = 1'b1;

  // behavioural model of the fetch stage
  bit          m_boot;
  bit          m_discard;
  logic [31:0] m_pc, m_addr, m_ifpc, m_instr;
  bit          m_v;
  logic [31:0] m_skid[$];
  logic [15:0] m_cnt;

  if_stage_ctrl dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .if_id_pc_o      (if_id_pc_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o),
    .bubble_o        (bubble_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0] ^ a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_boot = 1; m_discard = 0; m_pc = 0; m_addr = 0; m_ifpc = 0; m_instr = 0;
    m_v = 0; m_skid.delete(); m_cnt = 0;
  endtask

  task automatic m_step(input bit s, input bit f, input logic [31:0] t, input bit a);
    logic [31:0] tt;
    bit fl;
    tt = t & 32'hFFFF_FFFC;
    fl = f && !s;
    if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    if (m_boot) begin
      m_boot = 0;
      m_addr = m_pc;
    end else if (m_skid.size() != 0) begin
      if (!s) begin
        if (fl) begin
          m_pc = tt; m_addr = tt; m_v = 0; m_instr = 0;
        end else begin
          m_ifpc = m_pc; m_instr = m_skid[0]; m_v = 1; m_pc = m_pc + 4; m_addr = m_pc;
        end
        m_skid.delete();
      end
    end else if (m_discard) begin
      if (fl) m_pc = tt;
      if (a) begin
        m_discard = 0; m_addr = m_pc;
      end
    end else if (s) begin
      if (a) m_skid.push_back(mem(m_addr));
    end else if (fl) begin
      m_v = 0; m_instr = 0; m_pc = tt;
      if (a) m_addr = tt;
      else   m_discard = 1;
    end else if (a) begin
      m_ifpc = m_pc; m_instr = mem(m_addr); m_v = 1; m_pc = m_pc + 4; m_addr = m_pc;
    end else begin
      m_v = 0; m_instr = 0;
    end
  endtask

  task automatic cmp_all();
    chk("req", 64'(imem_req_o), 64'(!m_boot && m_skid.size() == 0));
    chk("addr", 64'(imem_addr_o), 64'(m_addr));
    chk("valid", 64'(if_id_valid_o), 64'(m_v));
    chk("instr", 64'(if_id_instr_o), 64'(m_instr));
    if (m_v) chk("if_id_pc", 64'(if_id_pc_o), 64'(m_ifpc));
    chk("bubble", 64'(bubble_o), 64'(stall_i && m_v));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
  endtask

  // called at a negedge: drive one cycle of inputs, advance the model, compare after the edge
  task automatic step(input bit s, input bit f, input logic [31:0] t, input bit a_en);
    stall_i = s;
    flush_i = f;
    branch_target_i = t;
    imem_ack_i = a_en && imem_req_o;
    imem_data_i = mem(imem_addr_o);
    m_step(s, f, t, imem_ack_i);
    @(posedge clk_i);
    @(negedge clk_i);
    if (do_cmp) cmp_all();
  endtask

  initial begin
    m_reset();
    imem_ack_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("reset_req", 64'(imem_req_o), 64'd0);
    chk("reset_valid", 64'(if_id_valid_o), 64'd0);
    rst_n = 1'b1;
    imem_ack_i = 1'b0;

    // zero-wait stream after boot
    step(0, 0, 0, 1);
    chk("boot_addr", 64'(imem_addr_o), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      chk("seq_pc", 64'(if_id_pc_o), 64'(i * 4));
      chk("seq_valid", 64'(if_id_valid_o), 64'd1);
    end

    // reset mid-FETCH with a pending request
    step(0, 0, 0, 0);
    chk("pending_req", 64'(imem_req_o), 64'd1);
    rst_n = 1'b0;
    imem_ack_i = 1'b1;
    #1;
    m_reset();
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_valid", 64'(if_id_valid_o), 64'd0);
    chk("rst_instr", 64'(if_id_instr_o), 64'd0);
    chk("rst_pc", 64'(if_id_pc_o), 64'd0);
    chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
    @(negedge clk_i);
    chk("rst_hold_req", 64'(imem_req_o), 64'd0);
    rst_n = 1'b1;
    imem_ack_i = 1'b0;
    step(0, 0, 0, 1);
    chk("reboot_addr", 64'(imem_addr_o), 64'h0);
    chk("reboot_req", 64'(imem_req_o), 64'd1);

    // stall while the fetch at 8 acks: skid keeps it, no refetch
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("stall_hold_pc", 64'(if_id_pc_o), 64'h4);
    chk("stall_no_req", 64'(imem_req_o), 64'd0);
    chk("stall_bubble", 64'(bubble_o), 64'd1);
    step(1, 0, 0, 1);
    chk("stall_cnt2", 64'(stall_cnt_o), 64'd2);
    step(0, 0, 0, 1);
    chk("skid_pc", 64'(if_id_pc_o), 64'h8);
    chk("skid_instr", 64'(if_id_instr_o), 64'(mem(32'h8)));
    chk("skid_next_addr", 64'(imem_addr_o), 64'hC);

    // flush while fetch at 0x10 is outstanding
    step(0, 0, 0, 1);
    step(0, 1, 32'h103, 0);
    chk("discard_addr", 64'(imem_addr_o), 64'h10);
    chk("discard_valid", 64'(if_id_valid_o), 64'd0);
    step(0, 0, 0, 1);
    chk("discard_drop_valid", 64'(if_id_valid_o), 64'd0);
    chk("redirect_addr", 64'(imem_addr_o), 64'h100);
    step(0, 0, 0, 1);
    chk("redirect_pc", 64'(if_id_pc_o), 64'h100);

    // stall and flush together: flush ignored
    step(1, 1, 32'h200, 0);
    chk("sf_addr", 64'(imem_addr_o), 64'h104);
    chk("sf_bubble", 64'(bubble_o), 64'd1);
    step(0, 0, 0, 1);
    chk("sf_pc", 64'(if_id_pc_o), 64'h104);

    // target low bits forced to zero and pc wraps
    step(0, 1, 32'hFFFF_FFFF, 1);
    chk("wrap_target", 64'(imem_addr_o), 64'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_pc", 64'(if_id_pc_o), 64'hFFFF_FFFC);
    chk("wrap_addr", 64'(imem_addr_o), 64'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom, $urandom_range(1) == 1);
    end

    // saturating stall counter
    do_cmp = 1'b0;
    for (int i = 0; i < 65539; i++) step(1, 0, 0, $urandom_range(1) == 1);
    do_cmp = 1'b1;
    step(1, 0, 0, 0);
    chk("cnt_sat", 64'(stall_cnt_o), 64'hFFFF);
    step(0, 0, 0, 1);
    chk("cnt_sat_hold", 64'(stall_cnt_o), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
